// File: rtl/dmem_lsu_if.sv
// Request/response channel between the MEM stage and the byte-addressed data memory.
// The master side issues loads/stores; the slave side returns one registered response per request.
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic [1:0]        resp_fault_code;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault, resp_fault_code
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressed single-port data memory with RV32I sized loads/stores, byte-lane merging,
// load extension, fault detection and a single-entry registered response slot.
module dmem_lsu #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_lsu_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_rword;
  logic              r_valid;
  logic              r_we;
  logic              r_fault;
  logic [1:0]        r_code;
  logic [1:0]        r_lane;
  logic [2:0]        r_f3;

  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_hi;
  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic [2:0]        w_f3;
  logic [1:0]        w_code;
  logic              w_fault;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_ext;

  assign w_addr  = bus.req_addr;
  assign w_f3    = bus.req_funct3;
  assign w_idx   = w_addr[IDX_W+1:2];
  assign w_lane  = w_addr[1:0];
  assign w_hi    = w_addr >> (IDX_W + 2);

  // The slot frees up in the same cycle the consumer drains it.
  assign bus.req_ready = !r_valid || bus.resp_ready;
  assign w_accept      = bus.req_valid && bus.req_ready && rst_n;

  always_comb begin
    w_code = 2'b00;
    if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) begin
      w_code = 2'b11;
    end else if ((w_f3[1:0] == 2'b01 && w_lane[0]) ||
                 (w_f3[1:0] == 2'b10 && w_lane != 2'b00)) begin
      w_code = 2'b01;
    end else if (w_hi != '0) begin
      w_code = 2'b10;
    end
  end

  assign w_fault = (w_code != 2'b00);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.req_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = bus.req_wdata;
      end
    endcase
  end

  assign w_wr_en = w_accept &&  bus.req_we && !w_fault;
  assign w_rd_en = w_accept && !bus.req_we && !w_fault;

  // Storage is not reset; the read register only loads on an accepted load so it holds through stalls.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
    if (w_rd_en) begin
      r_rword <= r_mem[w_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_code  <= 2'b00;
      r_lane  <= 2'b00;
      r_f3    <= 3'b000;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_we    <= bus.req_we;
      r_fault <= w_fault;
      r_code  <= w_code;
      r_lane  <= w_lane;
      r_f3    <= w_f3;
    end else if (bus.resp_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    w_byte = r_rword[8*r_lane +: 8];
    w_half = r_lane[1] ? r_rword[31:16] : r_rword[15:0];
    case (r_f3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = r_rword;
    endcase
  end

  // Stores, faulted loads and an empty slot all present zero data.
  assign bus.resp_valid      = r_valid;
  assign bus.resp_rdata      = (r_valid && !r_we && !r_fault) ? w_ext : 32'd0;
  assign bus.resp_fault      = r_valid && r_fault;
  assign bus.resp_fault_code = r_valid ? r_code : 2'b00;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios plus randomized streams checked against a byte-array model.
module tb_dmem_lsu;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [7:0] ref_mem [DEPTH*4];
  req_t       sq[$];

  dmem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_lsu #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 3ms");
    $fatal(1, "timeout");
  end

  // Reference: little-endian byte array; fault priority illegal > misaligned > out-of-range.
  function automatic exp_t model(input req_t r);
    exp_t        e;
    int          n;
    logic [31:0] v;
    e.rdata = 32'd0;
    e.code  = 2'd0;
    if (r.f3 == 3'd3 || r.f3 == 3'd6 || r.f3 == 3'd7) e.code = 2'd3;
    else if ((r.f3[1:0] == 2'd1 && (r.addr % 2) != 0) ||
             (r.f3[1:0] == 2'd2 && (r.addr % 4) != 0)) e.code = 2'd1;
    else if (r.addr >= 32'(DEPTH*4)) e.code = 2'd2;
    e.fault = (e.code != 2'd0);
    if (!e.fault) begin
      n = 1 << r.f3[1:0];
      if (r.we) begin
        for (int i = 0; i < n; i++) ref_mem[r.addr + i] = r.wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | ({24'd0, ref_mem[r.addr + i]} << (8*i));
        if (r.f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (r.f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e, output exp_t got, output int lat);
    req_t r;
    bit   seen;
    r = '{we, f3, addr, wdata};
    @(negedge clk);
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    e = model(r);
    #1 bus.req_valid = 1'b0;
    got  = '{32'd0, 1'b0, 2'd0};
    lat  = -1;
    seen = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (bus.resp_valid) begin
          seen = 1'b1;
          lat  = k;
          got  = '{bus.resp_rdata, bus.resp_fault, bus.resp_fault_code};
        end
      end
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready held low for 3 cycles after first response.
  task automatic run_stream(input string name, input int mode, output int span);
    exp_t        eq[$];
    exp_t        x;
    int          idx, got, n, first, last, stall_left;
    bit          seen, hold;
    logic [34:0] held, cur;
    idx = 0; got = 0; first = -1; last = -1; stall_left = 0; seen = 0; hold = 0; held = '0;
    n = sq.size();
    for (int cyc = 0; cyc < 20*n + 50 && got < n; cyc++) begin
      @(negedge clk);
      case (mode)
        0: bus.resp_ready = 1'b1;
        1: bus.resp_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus.resp_valid && !seen) begin
            seen = 1'b1;
            stall_left = 3;
          end
          bus.resp_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
      endcase
      if (idx < n) begin
        bus.req_valid  = 1'b1;
        bus.req_we     = sq[idx].we;
        bus.req_funct3 = sq[idx].f3;
        bus.req_addr   = sq[idx].addr;
        bus.req_wdata  = sq[idx].wdata;
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      cur = {bus.resp_rdata, bus.resp_fault, bus.resp_fault_code};
      if (bus.resp_valid) begin
        if (hold) begin
          n_cmp++;
          if (cur !== held) begin
            n_fail++;
            $display("FAIL %s stall_hold: resp=%h, required stable %h", name, cur, held);
          end
        end
        if (!bus.resp_ready) begin
          n_cmp++;
          if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall_ready: req_ready=%b, required 0", name, bus.req_ready);
          end
          hold = 1'b1;
          held = cur;
        end else begin
          hold = 1'b0;
          n_cmp++;
          if (eq.size() == 0) begin
            n_fail++;
            $display("FAIL %s spurious_resp: resp=%h with no request outstanding", name, cur);
          end else begin
            x = eq.pop_front();
            if (cur !== {x.rdata, x.fault, x.code}) begin
              n_fail++;
              $display("FAIL %s resp#%0d: got %h, required %h", name, got, cur, {x.rdata, x.fault, x.code});
            end
          end
          got++;
        end
      end else begin
        hold = 1'b0;
      end
      if (bus.req_valid && bus.req_ready) begin
        eq.push_back(model(sq[idx]));
        idx++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    n_cmp++;
    if (got != n) begin
      n_fail++;
      $display("FAIL %s resp_count: got %0d, required %0d", name, got, n);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s extra_resp: resp_valid=%b, required 0", name, bus.resp_valid);
      end
    end
    span = last - first;
    sq.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault, bus.resp_fault_code} !== {1'b1, 1'b0, 35'd0}) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b valid=%b rdata=%h fault=%b code=%b, required 1 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault, bus.resp_fault_code);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL post_reset: ready=%b valid=%b, required 1 0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int span;
    for (int w = 0; w < 64; w++) sq.push_back('{1'b1, 3'b010, 32'(w*4), $urandom});
    run_stream("preload_sw", 0, span);
    n_cmp++;
    if (span != 63) begin
      n_fail++;
      $display("FAIL b2b_store_span: %0d cycles, required 63", span);
    end
    for (int w = 0; w < 32; w++) sq.push_back('{1'b0, 3'b010, 32'(w*8), 32'd0});
    run_stream("b2b_lw", 0, span);
    n_cmp++;
    if (span != 31) begin
      n_fail++;
      $display("FAIL b2b_load_span: %0d cycles, required 31", span);
    end
  endtask

  task automatic test_basic();
    exp_t e, g;
    int   lat;
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, e, g, lat);
    n_cmp++;
    if (lat != 1 || {g.rdata, g.fault, g.code} !== {32'd0, 3'b000}) begin
      n_fail++; $display("FAIL sw_10: lat=%0d resp=%h, required lat=1 resp=%h", lat, {g.rdata, g.fault, g.code}, {32'd0, 3'b000});
    end
    issue(1'b0, 3'b010, 32'h10, 32'd0, e, g, lat);
    n_cmp++;
    if (lat != 1 || {g.rdata, g.fault, g.code} !== {32'hDEAD_BEEF, 3'b000}) begin
      n_fail++; $display("FAIL lw_10: lat=%0d resp=%h, required lat=1 resp=%h", lat, {g.rdata, g.fault, g.code}, {32'hDEAD_BEEF, 3'b000});
    end
    issue(1'b0, 3'b100, 32'h13, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'h0000_00DE, 3'b000}) begin
      n_fail++; $display("FAIL lbu_13: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'h0000_00DE, 3'b000});
    end
    issue(1'b0, 3'b000, 32'h13, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'hFFFF_FFDE, 3'b000}) begin
      n_fail++; $display("FAIL lb_13: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'hFFFF_FFDE, 3'b000});
    end
  endtask

  task automatic test_merge();
    exp_t e, g;
    int   lat;
    issue(1'b1, 3'b010, 32'h20, 32'h1122_3344, e, g, lat);
    issue(1'b1, 3'b000, 32'h21, 32'h1234_56AA, e, g, lat);
    issue(1'b1, 3'b001, 32'h22, 32'hABCD_5566, e, g, lat);
    issue(1'b0, 3'b010, 32'h20, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'h5566_AA44, 3'b000}) begin
      n_fail++; $display("FAIL merge_lw_20: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'h5566_AA44, 3'b000});
    end
    issue(1'b0, 3'b001, 32'h22, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'h0000_5566, 3'b000}) begin
      n_fail++; $display("FAIL merge_lh_22: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'h0000_5566, 3'b000});
    end
  endtask

  task automatic test_misaligned();
    exp_t e, g;
    int   lat;
    issue(1'b0, 3'b010, 32'h22, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'd0, 3'b101}) begin
      n_fail++; $display("FAIL mis_lw_22: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'd0, 3'b101});
    end
    issue(1'b1, 3'b001, 32'h21, 32'h0000_FFFF, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'd0, 3'b101}) begin
      n_fail++; $display("FAIL mis_sh_21: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'd0, 3'b101});
    end
    issue(1'b0, 3'b010, 32'h20, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'h5566_AA44, 3'b000}) begin
      n_fail++; $display("FAIL mis_nowrite: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'h5566_AA44, 3'b000});
    end
  endtask

  task automatic test_range_illegal();
    exp_t e, g;
    int   lat;
    issue(1'b1, 3'b010, 32'h1000, 32'h0BAD_F00D, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'd0, 3'b110}) begin
      n_fail++; $display("FAIL oor_sw_1000: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'd0, 3'b110});
    end
    issue(1'b0, 3'b010, 32'h0, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {e.rdata, e.fault, e.code} || g.rdata === 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL oor_nowrite: resp=%h, required %h", {g.rdata, g.fault, g.code}, {e.rdata, e.fault, e.code});
    end
    issue(1'b0, 3'b011, 32'h1, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'd0, 3'b111}) begin
      n_fail++; $display("FAIL ill_011_1: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'd0, 3'b111});
    end
    issue(1'b1, 3'b111, 32'h1003, 32'hFFFF_FFFF, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'd0, 3'b111}) begin
      n_fail++; $display("FAIL ill_111_1003: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'd0, 3'b111});
    end
    issue(1'b0, 3'b001, 32'h1001, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'd0, 3'b101}) begin
      n_fail++; $display("FAIL mis_over_oor: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'd0, 3'b101});
    end
    issue(1'b1, 3'b010, 32'hFFC, 32'h80C0_FFEE, e, g, lat);
    issue(1'b0, 3'b000, 32'hFFF, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'hFFFF_FF80, 3'b000}) begin
      n_fail++; $display("FAIL top_lb_fff: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'hFFFF_FF80, 3'b000});
    end
    issue(1'b0, 3'b001, 32'hFFE, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'hFFFF_80C0, 3'b000}) begin
      n_fail++; $display("FAIL top_lh_ffe: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'hFFFF_80C0, 3'b000});
    end
    issue(1'b0, 3'b101, 32'hFFE, 32'd0, e, g, lat);
    n_cmp++;
    if ({g.rdata, g.fault, g.code} !== {32'h0000_80C0, 3'b000}) begin
      n_fail++; $display("FAIL top_lhu_ffe: resp=%h, required %h", {g.rdata, g.fault, g.code}, {32'h0000_80C0, 3'b000});
    end
  endtask

  task automatic test_stall();
    int span;
    sq.push_back('{1'b0, 3'b010, 32'h10, 32'd0});
    sq.push_back('{1'b0, 3'b000, 32'h13, 32'd0});
    sq.push_back('{1'b0, 3'b010, 32'h20, 32'd0});
    sq.push_back('{1'b0, 3'b001, 32'h22, 32'd0});
    run_stream("stall4", 2, span);
  endtask

  task automatic test_random();
    int          span, sel;
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'($urandom_range(0, 255));
      else if (sel == 8) a = $urandom | 32'h0000_1000;
      else               a = 32'hFFC + 32'($urandom_range(0, 3));
      sq.push_back('{1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom});
    end
    run_stream("random", 1, span);
  endtask

  task automatic test_reset_pending();
    exp_t e, g;
    int   lat;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_pending_valid: resp_valid=%b, required 1", bus.resp_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault, bus.resp_fault_code} !== {1'b1, 1'b0, 35'd0}) begin
      n_fail++;
      $display("FAIL rst_async_clear: ready=%b valid=%b rdata=%h fault=%b code=%b, required 1 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_rdata, bus.resp_fault, bus.resp_fault_code);
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hCAFE_F00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.resp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_no_resp: resp_valid=%b, required 0", bus.resp_valid);
      end
    end
    issue(1'b0, 3'b010, 32'h20, 32'd0, e, g, lat);
    n_cmp++;
    if (lat != 1 || {g.rdata, g.fault, g.code} !== {e.rdata, e.fault, e.code}) begin
      n_fail++; $display("FAIL rst_mem_kept: lat=%0d resp=%h, required lat=1 resp=%h", lat, {g.rdata, g.fault, g.code}, {e.rdata, e.fault, e.code});
    end
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_back_to_back();
    test_basic();
    test_merge();
    test_misaligned();
    test_range_illegal();
    test_stall();
    test_random();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
